// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU load/store unit (master) and dmem_responder (slave).
// Optional byte-enable lane field present when DMEM_BYTE_EN is defined.
interface dmem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_BYTE_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_BYTE_EN
    output req_be,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_BYTE_EN
    input  req_be,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, WAIT_CYCLES wait states, then a held response.
// Optional per-byte store enables when DMEM_BYTE_EN is defined.
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
`ifdef DMEM_BYTE_EN
  logic [LANES-1:0]    be_q;
`endif
  logic                ready_q;
  logic                valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rsp_we_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Handshake flags are registered with the state; rst masks them so nothing completes under reset.
  assign bus.req_ready = ready_q & ~rst;
  assign bus.rsp_valid = valid_q & ~rst;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_we    = rsp_we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata_q  <= '0;
      rsp_we_q <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifdef DMEM_BYTE_EN
            be_q    <= bus.req_be;
`endif
            ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= ACCESS;
          else           cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rdata_q  <= we_q ? '0 : mem[addr_q];
          rsp_we_q <= we_q;
          valid_q  <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commits on the ACCESS edge, so any later load already sees it.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && we_q) begin
`ifdef DMEM_BYTE_EN
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be_q[i]) mem[addr_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
`else
      mem[addr_q] <= wdata_q;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Byte-enable cases run only when DMEM_BYTE_EN is defined.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();
  dmem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]  rv = '0;
  logic [1:0]  rr = '1;
  logic        t_we = 1'b0;
  logic [7:0]  t_addr = '0;
  logic [15:0] t_wdata = '0;
`ifdef DMEM_BYTE_EN
  logic [1:0]  t_be = '1;
  assign bus0.req_be = t_be;
  assign bus1.req_be = t_be;
`endif

  assign bus0.req_valid = rv[0];
  assign bus1.req_valid = rv[1];
  assign bus0.req_we    = t_we;
  assign bus1.req_we    = t_we;
  assign bus0.req_addr  = t_addr;
  assign bus1.req_addr  = t_addr;
  assign bus0.req_wdata = t_wdata;
  assign bus1.req_wdata = t_wdata;
  assign bus0.rsp_ready = rr[0];
  assign bus1.rsp_ready = rr[1];

  logic [1:0]  rdy, vo, wo;
  logic [15:0] rd [2];
  assign rdy = {bus1.req_ready, bus0.req_ready};
  assign vo  = {bus1.rsp_valid, bus0.rsp_valid};
  assign wo  = {bus1.rsp_we, bus0.rsp_we};
  always_comb begin
    rd[0] = bus0.rsp_rdata;
    rd[1] = bus1.rsp_rdata;
  end

  typedef struct {
    logic        we;
    logic [15:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] model [2][256];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // One full transaction on instance d; stall = cycles rsp_ready is held low once valid shows.
  task automatic txn(input int d, input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                     input logic [1:0] be, input int stall, output int acc_cyc);
    int n;
    exp_t e;
    logic [15:0] held;
    logic [1:0]  be_eff;
    acc_cyc = 0;
    @(negedge clk);
    t_we = we; t_addr = addr; t_wdata = wdata;
`ifdef DMEM_BYTE_EN
    t_be = be;
    be_eff = be;
`else
    be_eff = 2'b11;
`endif
    rr[d] = (stall == 0);
    rv[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 32'(n), 32'd0);
      rv[d] = 1'b0;
      rr[d] = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    rv[d] = 1'b0;
    // Scramble request inputs: they must be ignored outside the accept edge.
    t_we = 1'($urandom); t_addr = 8'($urandom); t_wdata = 16'($urandom);
    e.we   = we;
    e.data = we ? 16'h0 : model[d][addr];
    sbq.push_back(e);
    if (we) begin
      for (int i = 0; i < 2; i++)
        if (be_eff[i]) model[d][addr][i*8 +: 8] = wdata[i*8 +: 8];
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vo[d] && n < 40);
    if (!vo[d]) begin
      check("rsp_timeout", 32'(n), 32'(wait_of(d) + 2));
      rr[d] = 1'b1;
      void'(sbq.pop_front());
      return;
    end
    check("latency", 32'(n), 32'(wait_of(d) + 2));
    if (stall > 0) begin
      held = rd[d];
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_valid", 32'(vo[d]), 32'd1);
        check("stall_rdata", 32'(rd[d]), 32'(held));
        check("stall_ready", 32'(rdy[d]), 32'd0);
      end
      rr[d] = 1'b1;
    end
    e = sbq.pop_front();
    check("rsp_rdata", 32'(rd[d]), 32'(e.data));
    check("rsp_we", 32'(wo[d]), 32'(e.we));
    @(posedge clk);
    #1;
    check("idle_ready", 32'(rdy[d]), 32'd1);
    check("idle_valid", 32'(vo[d]), 32'd0);
  endtask

  int a0, a1, n;
  logic seen;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour
    repeat (2) begin
      @(negedge clk);
      check("rst_ready0", 32'(rdy[0]), 32'd0);
      check("rst_valid0", 32'(vo[0]), 32'd0);
      check("rst_rdata0", 32'(rd[0]), 32'd0);
      check("rst_ready1", 32'(rdy[1]), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(rdy[0]), 32'd1);

    // Store/load with two wait states, then backpressure
    txn(0, 1'b1, 8'h10, 16'hBEEF, 2'b11, 0, a0);
    txn(0, 1'b0, 8'h10, 16'h0000, 2'b11, 0, a1);
    check("spacing_w2", 32'(a1 - a0), 32'd5);
    txn(0, 1'b0, 8'h10, 16'h0000, 2'b11, 5, a0);

    // Zero wait states, top address
    txn(1, 1'b1, 8'hFF, 16'h1234, 2'b11, 0, a0);
    txn(1, 1'b0, 8'hFF, 16'h0000, 2'b11, 0, a1);
    check("spacing_w0", 32'(a1 - a0), 32'd3);
    txn(1, 1'b1, 8'h00, 16'h5A5A, 2'b11, 0, a0);
    txn(1, 1'b0, 8'h00, 16'h0000, 2'b11, 2, a0);

    // Reset during WAIT drops the store and its response
    txn(0, 1'b1, 8'h20, 16'h0000, 2'b11, 0, a0);
    @(negedge clk);
    t_we = 1'b1; t_addr = 8'h20; t_wdata = 16'hAAAA;
`ifdef DMEM_BYTE_EN
    t_be = 2'b11;
`endif
    rv[0] = 1'b1;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(vo[0]), 32'd0);
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    check("midrst_rdata", 32'(rd[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vo[0]) seen = 1'b1;
    end
    check("no_stale_rsp", 32'(seen), 32'd0);
    txn(0, 1'b0, 8'h20, 16'h0000, 2'b11, 0, a0);
    txn(0, 1'b0, 8'h10, 16'h0000, 2'b11, 0, a0);

`ifdef DMEM_BYTE_EN
    txn(0, 1'b1, 8'h30, 16'hFFFF, 2'b11, 0, a0);
    txn(0, 1'b1, 8'h30, 16'h1200, 2'b10, 0, a0);
    txn(0, 1'b0, 8'h30, 16'h0000, 2'b00, 0, a0);
    check("be_merge", 32'(model[0][8'h30]), 32'h12FF);
    txn(0, 1'b1, 8'h30, 16'hDEAD, 2'b00, 0, a0);
    txn(0, 1'b0, 8'h30, 16'h0000, 2'b11, 0, a0);
    txn(0, 1'b1, 8'h31, 16'hABCD, 2'b01, 0, a0);
`endif

    n = sbq.size();
    check("sb_empty", 32'(n), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
